pc_source_unit: RTL
===================

Name: pc_source_unit

Overview:
- Parametrised next-PC unit for the multicycle datapath.
- Selects the next-PC target from NUM_SRC packed sources and owns the PC register. It handles unconditional and branch-conditional writes.
- Detects illegal selector codes and misaligned targets, then redirects to a fault vector through a small FSM.
- Keeps the previous PC, the faulting address and a redirect counter for the control unit and the exception logic.

Parameters:
DATA_W, 32, width of PC and of every source.
NUM_SRC, 6, number of selectable sources (2..2**SEL_W).
SEL_W, 3, selector width.
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
FAULT_VEC, 32'h0000_00FC, PC value loaded when a fault is taken.
ALIGN_CHECK, 1, 1 enables the word-alignment check (target[1:0] must be 2'b00).
CNT_W, 8, width of the redirect counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
sel  input  SEL_W  source select; code k selects src_data[k*DATA_W +: DATA_W].
src_data  input  NUM_SRC*DATA_W  packed candidate targets; source 0 is in the LSBs.
pc_write  input  1  unconditional PC write request.
pc_write_cond  input  1  conditional (branch) write request.
branch_taken  input  1  branch condition from the ALU flags; qualifies pc_write_cond.
clear_err  input  1  clears the sticky error flags.
pc  output  DATA_W  current PC (registered).
pc_prev  output  DATA_W  PC value before the last update.
fault_addr  output  DATA_W  rejected target, or the PC at the time of an illegal selector.
err_sel  output  1  sticky: illegal selector seen.
err_align  output  1  sticky: misaligned target seen.
pc_valid  output  1  1 when pc is a usable fetch address.
upd_cnt  output  CNT_W  number of accepted PC updates, wrapping.

Behaviour:
- Reset (reset=0, asynchronous, any cycle, including mid-fault):
  - pc=RESET_VEC, pc_prev=RESET_VEC, fault_addr=0.
  - err_sel=0, err_align=0, upd_cnt=0, pc_valid=0.
  - FSM enters S_BOOT.
- Write qualification: upd = pc_write | (pc_write_cond & branch_taken).
- Target: src_data slice at index sel. The slice is only used when sel < NUM_SRC.
- FSM states: S_BOOT, S_RUN, S_FAULT.
- S_BOOT:
  - Lasts exactly one cycle after reset deassertion; pc_valid=0.
  - upd is ignored.
  - Next state is S_RUN.
- S_RUN (pc_valid=1), evaluated at each rising edge:
  - upd=0: all registers hold.
  - upd=1 and sel >= NUM_SRC: pc and upd_cnt hold, err_sel<=1, fault_addr<=pc, go to S_FAULT.
  - upd=1, ALIGN_CHECK=1 and target[1:0] != 0: pc holds, err_align<=1, fault_addr<=target, go to S_FAULT.
  - Illegal selector has priority over misalignment.
  - Otherwise, with upd=1: pc<=target, pc_prev<=pc, upd_cnt<=upd_cnt+1 (wraps to 0 from all-ones).
- S_FAULT (pc_valid=0 for exactly one cycle):
  - pc<=FAULT_VEC, pc_prev<=pc, upd_cnt<=upd_cnt+1.
  - upd is ignored.
  - Next state is S_RUN.
- Latency:
  - Accepted update: new pc is visible on the cycle after the edge.
  - Fault: FAULT_VEC is visible two cycles after the offending edge.
- clear_err:
  - Clears err_sel and err_align at the edge.
  - If a new fault is detected on the same edge, set wins.
  - fault_addr is not cleared.
- Output timing: all outputs are registered or decoded from the FSM state only. No combinational path from inputs to outputs.
- Elaboration: NUM_SRC > 2**SEL_W or NUM_SRC < 2 is an elaboration error.

Test Plan:
- Reset, then 1 idle cycle -> pc=0, pc_valid=0 in S_BOOT, 1 after; upd_cnt=0; flags=0.
- sel=2, src2=0x0000_0040, pc_write=1 for one cycle -> next cycle pc=0x40, pc_prev=0x0, upd_cnt=1.
- pc_write_cond=1 with branch_taken=0 (sel=1, src1=0x80) -> pc holds. Repeat with branch_taken=1 -> pc=0x80.
- pc=0x80, sel=7, pc_write=1 -> err_sel=1, fault_addr=0x80, pc_valid=0 one cycle, then pc=0xFC, pc_prev=0x80.
- sel=0, src0=0x102, pc_write=1 -> err_align=1, fault_addr=0x102, then pc=0xFC. A simultaneous clear_err leaves err_align=1.
- reset asserted during S_FAULT -> pc=0 and flags=0 immediately (asynchronous). Separately, 256 accepted updates -> upd_cnt wraps to 0.

Source files
------------

// File: rtl/pc_source_unit.sv
// ============================================================================
// Module   : pc_source_unit
// Purpose  : Next-PC selection, PC register and fault redirect for the
//            multicycle datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_source_unit #(
  parameter int                DATA_W      = 32,
  parameter int                NUM_SRC     = 6,
  parameter int                SEL_W       = 3,
  parameter logic [DATA_W-1:0] RESET_VEC   = '0,
  parameter logic [DATA_W-1:0] FAULT_VEC   = DATA_W'(32'h0000_00FC),
  parameter int                ALIGN_CHECK = 1,
  parameter int                CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      pc_write,
  input  logic                      pc_write_cond,
  input  logic                      branch_taken,
  input  logic                      clear_err,
  output logic [DATA_W-1:0]         pc,
  output logic [DATA_W-1:0]         pc_prev,
  output logic [DATA_W-1:0]         fault_addr,
  output logic                      err_sel,
  output logic                      err_align,
  output logic                      pc_valid,
  output logic [CNT_W-1:0]          upd_cnt
);

  localparam logic c_align_en = (ALIGN_CHECK != 0);

  generate
    if (NUM_SRC < 2 || NUM_SRC > (1 << SEL_W)) begin : g_bad_num_src
      $error("pc_source_unit: NUM_SRC must be in 2..2**SEL_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   pc_prev_q, pc_prev_d;
  logic [DATA_W-1:0]   fault_addr_q, fault_addr_d;
  logic                err_sel_q, err_sel_d;
  logic                err_align_q, err_align_d;
  logic [CNT_W-1:0]    upd_cnt_q, upd_cnt_d;

  logic                w_upd;
  logic                w_sel_ok;
  logic                w_misaligned;
  logic [DATA_W-1:0]   w_target;

  assign w_upd    = pc_write | (pc_write_cond & branch_taken);
  assign w_sel_ok = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC));

  // Out-of-range selectors never index src_data; they yield zero instead.
  always_comb begin
    w_target = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel == SEL_W'(k)) begin
        w_target = src_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_misaligned = c_align_en && (w_target[1:0] != 2'b00);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_prev_d    = pc_prev_q;
    fault_addr_d = fault_addr_q;
    err_sel_d    = clear_err ? 1'b0 : err_sel_q;
    err_align_d  = clear_err ? 1'b0 : err_align_q;
    upd_cnt_d    = upd_cnt_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (w_upd) begin
          if (!w_sel_ok) begin
            err_sel_d    = 1'b1;
            fault_addr_d = pc_q;
            state_d      = S_FAULT;
          end else if (w_misaligned) begin
            err_align_d  = 1'b1;
            fault_addr_d = w_target;
            state_d      = S_FAULT;
          end else begin
            pc_d      = w_target;
            pc_prev_d = pc_q;
            upd_cnt_d = upd_cnt_q + 1'b1;
          end
        end
      end
      S_FAULT: begin
        pc_d      = FAULT_VEC;
        pc_prev_d = pc_q;
        upd_cnt_d = upd_cnt_q + 1'b1;
        state_d   = S_RUN;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_VEC;
      pc_prev_q    <= RESET_VEC;
      fault_addr_q <= '0;
      err_sel_q    <= 1'b0;
      err_align_q  <= 1'b0;
      upd_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_prev_q    <= pc_prev_d;
      fault_addr_q <= fault_addr_d;
      err_sel_q    <= err_sel_d;
      err_align_q  <= err_align_d;
      upd_cnt_q    <= upd_cnt_d;
    end
  end

  assign pc         = pc_q;
  assign pc_prev    = pc_prev_q;
  assign fault_addr = fault_addr_q;
  assign err_sel    = err_sel_q;
  assign err_align  = err_align_q;
  assign pc_valid   = (state_q == S_RUN);
  assign upd_cnt    = upd_cnt_q;

endmodule

`default_nettype wire
